conv3x3_window: RTL and testbench

//  Downstream consumer of the two-line LineBuffer chain: takes one column of three vertically

---
 rtl/conv3x3_window_if.sv | 30 +++
 rtl/conv3x3_window.sv | 152 +++++++++++++++
 tb/tb_conv3x3_window.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_window_if.sv
// Column-sample and result bundle for conv3x3_window.
// Valid-only streaming: a column is consumed on every rising edge with in_valid=1 (no ready/backpressure);
// out_valid marks a result for exactly one cycle and the consumer must take it then.
`timescale 1ns/1ps
interface conv3x3_window_if #(
  parameter int DATA_WIDTH = 14,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 14
);
  logic                    in_valid;
  logic                    in_sof;
  logic [DATA_WIDTH-1:0]   row0_in;
  logic [DATA_WIDTH-1:0]   row1_in;
  logic [DATA_WIDTH-1:0]   row2_in;
  logic [9*COEF_WIDTH-1:0] coef_flat;
  logic                    out_valid;
  logic [OUT_WIDTH-1:0]    out_data;
  logic                    out_eol;
  logic                    frame_done;

  modport master (
    output in_valid, in_sof, row0_in, row1_in, row2_in, coef_flat,
    input  out_valid, out_data, out_eol, frame_done
  );

  modport slave (
    input  in_valid, in_sof, row0_in, row1_in, row2_in, coef_flat,
    output out_valid, out_data, out_eol, frame_done
  );
endinterface

// File: rtl/conv3x3_window.sv
// 3x3 sliding-window convolution over a three-row column stream, emitting one clamped result per full window.
// Optional macro CONV_ABS_EN: negative sums are output as |sum| instead of clamping to 0.
`timescale 1ns/1ps
module conv3x3_window #(
  parameter int DATA_WIDTH = 14,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 14,
  parameter int IMG_WIDTH  = 100,
  parameter int IMG_HEIGHT = 100
) (
  input logic              Clk,
  input logic              Rst_n,
  conv3x3_window_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int PW = DATA_WIDTH + 1 + COEF_WIDTH;
  localparam int SW = PW + 4;

  localparam logic [CW-1:0]        COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]        ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic signed [SW-1:0] OUT_MAX   = SW'((2 ** OUT_WIDTH) - 1);
  localparam logic [OUT_WIDTH-1:0] OUT_MAX_U = {OUT_WIDTH{1'b1}};

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  // Window and kernel are indexed 3*r+c, r/c=0 being the oldest row/column.
  logic [DATA_WIDTH-1:0]        win_q[9], win_d[9];
  logic signed [COEF_WIDTH-1:0] kern_q[9], kern_d[9];
  logic signed [PW-1:0]         prod_q[9], prod_d[9];
  logic signed [SW-1:0]         sum_q, sum_d, mag;

  logic v1_q, v1_d, eol1_q, eol1_d;
  logic v2_q, eol2_q;
  logic v3_q, eol3_q;
  logic                 out_valid_q, out_eol_q;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 frame_done_q, frame_done_d;

  // S1: position tracking, kernel latch and window shift on each accepted column
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    kern_d       = kern_q;
    v1_d         = 1'b0;
    eol1_d       = 1'b0;
    frame_done_d = 1'b0;
    cur_col      = bus.in_sof ? '0 : col_q;
    cur_row      = bus.in_sof ? '0 : row_q;
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        for (int i = 0; i < 9; i++) kern_d[i] = bus.coef_flat[i*COEF_WIDTH +: COEF_WIDTH];
      end
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = bus.row2_in;
      win_d[5] = bus.row1_in;
      win_d[8] = bus.row0_in;
      v1_d     = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
      eol1_d   = (cur_col == COL_LAST);
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = cur_row + 1'b1;
        end
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  // S2: pixels are zero-extended so they multiply as non-negative signed values
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = PW'($signed({1'b0, win_q[i]})) * PW'(kern_q[i]);
    end
  end

  // S3: adder tree
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) sum_d = sum_d + SW'(prod_q[i]);
  end

  // S4: rectify then saturate to the output range
  always_comb begin
    mag = sum_q;
    if (sum_q[SW-1]) begin
`ifdef CONV_ABS_EN
      mag = -sum_q;
`else
      mag = '0;
`endif
    end
    out_data_d = (mag > OUT_MAX) ? OUT_MAX_U : mag[OUT_WIDTH-1:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i]  <= '0;
        kern_q[i] <= '0;
        prod_q[i] <= '0;
      end
      sum_q        <= '0;
      v1_q         <= 1'b0;
      eol1_q       <= 1'b0;
      v2_q         <= 1'b0;
      eol2_q       <= 1'b0;
      v3_q         <= 1'b0;
      eol3_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_eol_q    <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      kern_q       <= kern_d;
      prod_q       <= prod_d;
      sum_q        <= sum_d;
      v1_q         <= v1_d;
      eol1_q       <= eol1_d;
      v2_q         <= v1_q;
      eol2_q       <= eol1_q;
      v3_q         <= v2_q;
      eol3_q       <= eol2_q;
      out_valid_q  <= v3_q;
      out_eol_q    <= v3_q & eol3_q;
      out_data_q   <= v3_q ? out_data_d : '0;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_eol    = out_eol_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_window.sv
// Self-checking bench for conv3x3_window on an 8x6 frame: directed kernels plus randomized frames
// checked against a direct 3x3 convolution of the stored image.
`timescale 1ns/1ps
module tb_conv3x3_window;
  localparam int DW = 14;
  localparam int KW = 8;
  localparam int OW = 14;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int OMAX = (1 << OW) - 1;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  conv3x3_window_if #(.DATA_WIDTH(DW), .COEF_WIDTH(KW), .OUT_WIDTH(OW)) bus ();

  conv3x3_window #(
    .DATA_WIDTH(DW), .COEF_WIDTH(KW), .OUT_WIDTH(OW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int img[IH][IW];
  int kmat[3][3];

  logic [OW-1:0] exp_q[$];
  logic          exp_eol_q[$];
  int            exp_cyc_q[$];
  int out_cnt, eol_cnt, fd_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: direct convolution of the stored image, then rectify and saturate.
  function automatic int ref_result(input int r, input int c);
    int s = 0;
    for (int kr = 0; kr < 3; kr++)
      for (int kc = 0; kc < 3; kc++)
        s += kmat[kr][kc] * img[r - 2 + kr][c - 2 + kc];
`ifdef CONV_ABS_EN
    if (s < 0) s = -s;
`else
    if (s < 0) s = 0;
`endif
    if (s > OMAX) s = OMAX;
    return s;
  endfunction

  always @(negedge Clk) begin
    if (Rst_n === 1'b1) begin
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.out_valid === 1'b1) begin
        out_cnt++;
        if (bus.out_eol === 1'b1) eol_cnt++;
        check_eq("out_valid_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_eq("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
          check_eq("out_eol", 32'(bus.out_eol), 32'(exp_eol_q.pop_front()));
          check_eq("out_latency_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end else begin
        check_eq("eol_without_valid", 32'(bus.out_eol), 32'd0);
      end
    end
  end

  task automatic set_kernel(input int k);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) kmat[r][c] = k;
  endtask

  task automatic load_coef();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) bus.coef_flat[(3*r+c)*KW +: KW] = KW'(kmat[r][c]);
  endtask

  task automatic fill_img(input int mode, input int v);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++)
        img[r][c] = (mode == 0) ? r * IW + c : (mode == 1) ? v : int'($urandom_range(0, v));
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    @(posedge Clk); #1;
  endtask

  // gap_mode: 0 continuous, 1 valid toggling, 2 random gaps
  task automatic drive_frame(input int npix, input int gap_mode);
    int r, c;
    out_cnt = 0; eol_cnt = 0; fd_cnt = 0;
    load_coef();
    for (int p = 0; p < npix; p++) begin
      r = p / IW;
      c = p % IW;
      if (gap_mode == 1 && p > 0) idle_cycle();
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
      bus.in_valid = 1'b1;
      bus.in_sof   = (p == 0);
      bus.row0_in  = DW'(img[r][c]);
      bus.row1_in  = (r >= 1) ? DW'(img[r-1][c]) : DW'($urandom);
      bus.row2_in  = (r >= 2) ? DW'(img[r-2][c]) : DW'($urandom);
      @(posedge Clk); #1;
      if (r >= 2 && c >= 2) begin
        exp_q.push_back(OW'(ref_result(r, c)));
        exp_eol_q.push_back(c == IW - 1);
        exp_cyc_q.push_back(cyc + 3);
      end
      if (p == IW * IH - 1) check_eq("frame_done_pulse", 32'(bus.frame_done), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge Clk); #1;
    end
    repeat (3) @(posedge Clk);
    #1;
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_out_count"}, 32'(out_cnt), 32'((IW - 2) * (IH - 2)));
    check_eq({tag, "_eol_count"}, 32'(eol_cnt), 32'(IH - 2));
    check_eq({tag, "_frame_done_count"}, 32'(fd_cnt), 32'd1);
    exp_q.delete(); exp_eol_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check_eq({tag, "_out_eol"}, 32'(bus.out_eol), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    bus.row0_in = '0; bus.row1_in = '0; bus.row2_in = '0; bus.coef_flat = '0;
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    reset_checks("reset");
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Identity kernel on a ramp: first result 9
    set_kernel(0); kmat[1][1] = 1; fill_img(0, 0);
    drive_frame(IW * IH, 0);
    finish_frame("identity");

    set_kernel(1); fill_img(1, 100);
    drive_frame(IW * IH, 0);
    finish_frame("box_900");

    set_kernel(127); fill_img(1, 16383);
    drive_frame(IW * IH, 0);
    finish_frame("saturate");

    set_kernel(0); kmat[1][1] = -1; fill_img(1, 50);
    drive_frame(IW * IH, 0);
    finish_frame("negative");

    set_kernel(0); kmat[1][1] = 1; fill_img(0, 0);
    drive_frame(IW * IH, 1);
    finish_frame("toggle_valid");

    // Reset in the middle of a frame discards everything in flight
    drive_frame(20, 0);
    Rst_n = 1'b0;
    exp_q.delete(); exp_eol_q.delete(); exp_cyc_q.delete();
    repeat (2) @(posedge Clk);
    #1;
    reset_checks("midframe_reset");
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    drive_frame(IW * IH, 0);
    finish_frame("after_reset");

    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          kmat[r][c] = (f == 0) ? int'($urandom_range(0, 8)) - 4 : int'($urandom_range(0, 255)) - 128;
      fill_img(2, (f == 0) ? 1000 : 16383);
      drive_frame(IW * IH, (f == 2) ? 2 : 0);
      finish_frame("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
